// File: rtl/spi_pixel_scheduler_pkg.sv
// pixel_sched_pkg: shared states, descriptor layout and defaults for the SPI pixel scheduler
package pixel_sched_pkg;
    localparam int DEF_COORD_W = 8;
    localparam int DEF_ID_W    = 16;
    localparam int ID_LSB      = 16;
    localparam int W_LSB       = 8;
    localparam int H_LSB       = 0;
    typedef enum logic [2:0] {IDLE, WAIT, CHECK, RUN, DONE} state_t;
    typedef struct packed {
        logic [15:0] id;
        logic [7:0]  width;
        logic [7:0]  height;
    } desc_t;
    function automatic desc_t unpack_desc(input logic [31:0] word);
        return '{id: word[ID_LSB +: 16], width: word[W_LSB +: 8], height: word[H_LSB +: 8]};
    endfunction
endpackage

// File: rtl/spi_pixel_scheduler_raster_counter.sv
// raster_counter: x/y raster walker; wrap flags the final column, last the final row
module raster_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         advance,
    input  logic [W-1:0] width,
    input  logic [W-1:0] height,
    output logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic         wrap,
    output logic         last
);
    assign wrap = x == width - W'(1);
    assign last = y == height - W'(1);
    // the final coordinate wraps both axes so counters never pass W-1/H-1
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            x <= wrap ? '0 : x + W'(1);
            y <= wrap ? (last ? '0 : y + W'(1)) : y;
        end
endmodule

// File: rtl/spi_pixel_scheduler.sv
// spi_pixel_scheduler: pops frame descriptors from the SPI FIFO and issues raster pixels
// Defining PIXEL_SCHED_STATS_EN adds saturating frame/zero-size/stall counters.
module spi_pixel_scheduler
    import pixel_sched_pkg::*;
#(
    parameter int COORD_W    = DEF_COORD_W,
    parameter int ID_W       = DEF_ID_W,
    parameter int RD_LATENCY = 1
) (
    input  logic               rd_clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               fifo_empty,
    output logic               fifo_rd_en,
    input  logic [31:0]        fifo_dout,
    output logic               px_valid,
    input  logic               px_ready,
    output logic [COORD_W-1:0] px_x,
    output logic [COORD_W-1:0] px_y,
    output logic [ID_W-1:0]    px_id,
    output logic               px_last,
    output logic               frame_busy,
    output logic               frame_done,
    output logic               err_zero
`ifdef PIXEL_SCHED_STATS_EN
    ,
    output logic [15:0]        stat_frames,
    output logic [15:0]        stat_zero,
    output logic [31:0]        stat_stall
`endif
);
    state_t state, state_n;
    desc_t desc;
    logic [1:0] wait_cnt;
    logic [COORD_W-1:0] w_q, h_q;
    logic pop, zero, accept, wrap, last;

    assign desc       = unpack_desc(fifo_dout);
    assign zero       = w_q == '0 || h_q == '0;
    assign pop        = state == IDLE && enable && !fifo_empty;
    assign accept     = px_valid && px_ready;
    assign fifo_rd_en = pop;
    assign px_valid   = state == RUN;
    assign px_last    = px_valid && wrap && last;
    assign frame_busy = state != IDLE;
    assign frame_done = state == DONE;
    assign err_zero   = state == CHECK && zero;

    always_ff @(posedge rd_clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = pop ? WAIT : IDLE;
            WAIT:    state_n = wait_cnt == 2'd1 ? CHECK : WAIT;
            CHECK:   state_n = zero ? IDLE : RUN;
            RUN:     state_n = accept && wrap && last ? DONE : RUN;
            default: state_n = IDLE;
        endcase
    end

    // descriptor is captured on the final wait count, when the FIFO output is valid
    always_ff @(posedge rd_clk or posedge rst)
        if (rst) begin
            wait_cnt <= '0;
            px_id    <= '0;
            w_q      <= '0;
            h_q      <= '0;
        end else if (pop) begin
            wait_cnt <= 2'(RD_LATENCY);
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt - 2'd1;
            if (wait_cnt == 2'd1) begin
                px_id <= ID_W'(desc.id);
                w_q   <= COORD_W'(desc.width);
                h_q   <= COORD_W'(desc.height);
            end
        end

    raster_counter #(.W(COORD_W)) u_raster (
        .clk     (rd_clk),
        .rst     (rst),
        .clear   (state == CHECK),
        .advance (accept),
        .width   (w_q),
        .height  (h_q),
        .x       (px_x),
        .y       (px_y),
        .wrap    (wrap),
        .last    (last)
    );

`ifdef PIXEL_SCHED_STATS_EN
    always_ff @(posedge rd_clk or posedge rst)
        if (rst) begin
            stat_frames <= '0;
            stat_zero   <= '0;
            stat_stall  <= '0;
        end else begin
            if (frame_done && !(&stat_frames)) stat_frames <= stat_frames + 16'd1;
            if (err_zero && !(&stat_zero)) stat_zero <= stat_zero + 16'd1;
            if (px_valid && !px_ready && !(&stat_stall)) stat_stall <= stat_stall + 32'd1;
        end
`endif
endmodule

// File: tb/tb_spi_pixel_scheduler.sv
// tb_spi_pixel_scheduler: randomized bench with a frame-level reference model of the scheduler
module tb_spi_pixel_scheduler;
    localparam int LAT = 1;
    typedef logic [32:0] pix_t;

    logic rd_clk = 0, rst = 1, enable = 0, px_ready = 0;
    logic fifo_empty, fifo_rd_en, px_valid, px_last, frame_busy, frame_done, err_zero;
    logic [31:0] fifo_dout;
    logic [7:0] px_x, px_y;
    logic [15:0] px_id;
`ifdef PIXEL_SCHED_STATS_EN
    logic [15:0] stat_frames, stat_zero;
    logic [31:0] stat_stall;
`endif

    int checks = 0, errors = 0;
    logic [31:0] mem [256];
    logic [31:0] pipe [3];
    int wr_ptr = 0, rd_ptr = 0;
    int rdy_mode = 0;
    bit phase = 0;

    spi_pixel_scheduler #(.RD_LATENCY(LAT)) dut (
        .rd_clk     (rd_clk),
        .rst        (rst),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .px_valid   (px_valid),
        .px_ready   (px_ready),
        .px_x       (px_x),
        .px_y       (px_y),
        .px_id      (px_id),
        .px_last    (px_last),
        .frame_busy (frame_busy),
        .frame_done (frame_done),
        .err_zero   (err_zero)
`ifdef PIXEL_SCHED_STATS_EN
        ,
        .stat_frames(stat_frames),
        .stat_zero  (stat_zero),
        .stat_stall (stat_stall)
`endif
    );

    always #5 rd_clk = ~rd_clk;

    // FIFO model: word appears LAT cycles after the pop, garbage otherwise
    assign fifo_empty = wr_ptr == rd_ptr;
    assign fifo_dout  = pipe[LAT-1];
    always @(posedge rd_clk) begin
        pipe[0] <= fifo_rd_en ? mem[rd_ptr % 256] : $urandom;
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
        if (fifo_rd_en) rd_ptr <= rd_ptr + 1;
    end

    initial forever begin
        @(posedge rd_clk);
        #1;
        phase = ~phase;
        px_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? phase :
                   rdy_mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    pix_t exp_q[$];
    pix_t held, cur;
    logic [31:0] d;
    int w, h, cyc = 0, rd_cyc = 0;
    int n_px = 0, n_done = 0, n_err = 0, n_rd = 0, n_stall = 0;
    int tot_done = 0, tot_err = 0, tot_stall = 0;
    bit first_pend = 0, stalled = 0;

    always @(negedge rd_clk) begin
        if (rst) begin
            exp_q.delete();
            stalled = 0;
            first_pend = 0;
            tot_done = 0;
            tot_err = 0;
            tot_stall = 0;
        end else begin
            cyc++;
            if (fifo_rd_en) begin
                n_rd++;
                check("rd_en_idle", frame_busy, 0);
                check("rd_en_gate", enable && !fifo_empty, 1);
                d = mem[rd_ptr % 256];
                w = int'(d[15:8]);
                h = int'(d[7:0]);
                if (w != 0 && h != 0) begin
                    first_pend = 1;
                    rd_cyc = cyc;
                    for (int yy = 0; yy < h; yy++)
                        for (int xx = 0; xx < w; xx++)
                            exp_q.push_back({d[31:16], 8'(xx), 8'(yy), 1'((xx == w - 1) && (yy == h - 1))});
                end
            end
            cur = {px_id, px_x, px_y, px_last};
            if (px_valid) begin
                if (first_pend) check("first_px_latency", 64'(cyc - rd_cyc), 64'(LAT + 2));
                first_pend = 0;
                if (stalled) check("stall_stable", cur, held);
                if (px_ready) begin
                    n_px++;
                    stalled = 0;
                    if (exp_q.size() == 0) check("px_unexpected", 1, 0);
                    else check("px_{id,x,y,last}", cur, exp_q.pop_front());
                end else begin
                    stalled = 1;
                    held = cur;
                    n_stall++;
                    tot_stall++;
                end
            end
            if (frame_done) begin n_done++; tot_done++; end
            if (err_zero) begin n_err++; tot_err++; end
        end
    end

    task automatic push(input logic [31:0] v);
        @(posedge rd_clk);
        #1;
        mem[wr_ptr % 256] = v;
        wr_ptr++;
    endtask

    task automatic clear_counts();
        n_px = 0; n_done = 0; n_err = 0; n_rd = 0; n_stall = 0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            @(negedge rd_clk);
            n++;
        end while (!(fifo_empty && !frame_busy) && n < 6000);
        check({tag, "_timeout"}, n < 6000, 1);
        repeat (2) @(negedge rd_clk);
    endtask

    task automatic expect_counts(input string tag, input int px, input int done, input int err);
        check({tag, "_pixels"}, n_px, px);
        check({tag, "_frame_done"}, n_done, done);
        check({tag, "_err_zero"}, n_err, err);
        check({tag, "_model_drained"}, exp_q.size(), 0);
    endtask

    int ep, ed, ee, rw, rh, n;

    initial begin
        repeat (3) @(posedge rd_clk);
        @(negedge rd_clk);
        check("reset_outputs", {fifo_rd_en, px_valid, px_x, px_y, px_id, px_last, frame_busy, frame_done, err_zero}, 0);
        @(posedge rd_clk);
        #1 rst = 0;
        enable = 1;

        clear_counts();
        push(32'h00000F0F);
        wait_idle("single");
        expect_counts("single", 225, 1, 0);

        clear_counts();
        rdy_mode = 1;
        push(32'h00070302);
        wait_idle("backpressure");
        expect_counts("backpressure", 6, 1, 0);
        check("backpressure_stalled", n_stall > 0, 1);
        rdy_mode = 0;

        clear_counts();
        push(32'h00000500);
        wait_idle("zero");
        expect_counts("zero", 0, 0, 1);
        push(32'h00000101);
        wait_idle("one_px");
        expect_counts("one_px", 1, 1, 1);

        clear_counts();
        for (int i = 0; i < 10; i++) push(32'h00000F0F);
        wait_idle("b2b");
        expect_counts("b2b", 2250, 10, 0);

        clear_counts();
        @(posedge rd_clk);
        #1 enable = 0;
        push(32'h00020303);
        repeat (20) @(negedge rd_clk);
        check("disabled_rd_en", n_rd, 0);
        check("disabled_fifo_kept", fifo_empty, 0);
        @(posedge rd_clk);
        #1 enable = 1;
        wait_idle("enable");
        expect_counts("enable", 9, 1, 0);

        clear_counts();
        ep = 0; ed = 0; ee = 0;
        rdy_mode = 2;
        for (int i = 0; i < 8; i++) begin
            rw = $urandom_range(0, 6);
            rh = $urandom_range(0, 6);
            push({16'($urandom), 8'(rw), 8'(rh)});
            if (rw == 0 || rh == 0) ee++;
            else begin ep += rw * rh; ed++; end
        end
        push(32'h00550505);
        ep += 25; ed++;
        repeat (12) @(negedge rd_clk);
        rdy_mode = 3;
        repeat (25) @(negedge rd_clk);
        rdy_mode = 2;
        wait_idle("random");
        expect_counts("random", ep, ed, ee);
        rdy_mode = 0;
`ifdef PIXEL_SCHED_STATS_EN
        check("stat_frames", stat_frames, tot_done);
        check("stat_zero", stat_zero, tot_err);
        check("stat_stall", stat_stall, tot_stall);
`endif

        clear_counts();
        push(32'h00000F0F);
        n = 0;
        do begin
            @(negedge rd_clk);
            n++;
        end while (n_px < 50 && n < 1000);
        check("reset_reach_px50", n < 1000, 1);
        #2 rst = 1;
        #1;
        check("midframe_reset_outputs", {fifo_rd_en, px_valid, px_x, px_y, px_id, px_last, frame_busy, frame_done, err_zero}, 0);
`ifdef PIXEL_SCHED_STATS_EN
        check("stats_cleared", {stat_frames, stat_zero, stat_stall}, 0);
`endif
        @(negedge rd_clk);
        @(posedge rd_clk);
        #1 rst = 0;
        clear_counts();
        push(32'h00040202);
        wait_idle("after_reset");
        expect_counts("after_reset", 4, 1, 0);
`ifdef PIXEL_SCHED_STATS_EN
        check("stat_frames_post", stat_frames, tot_done);
        check("stat_stall_post", stat_stall, tot_stall);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
